mem_port_arbiter: RTL

//  Shares the single-ported unified instruction/data memory between two requesters:
//   - the core: multicycle control FSM fetch, load and store traffic;
//   - a debug/loader port used for program download and memory inspection.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester ports and memory-macro side of mem_port_arbiter
// master: the arbiter itself; slave: the requesters and memory that surround it.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  logic          busy;
  logic          grant;

  modport master (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_ack,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata,
    output busy, grant
  );

  modport slave (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_ack,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata,
    input  busy, grant
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - core/debug req-ack arbiter for a fixed-wait-state single-ported memory
// MEM_ARB_RR_EN: round-robin on simultaneous requests; undefined gives fixed core priority.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int WAIT_CYC = 2
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  localparam int CW = $clog2(WAIT_CYC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic          grant_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] c_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          pick_d;

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  // On a tie the port that did not own the previous access wins.
  assign pick_d = bus.d_req & (~bus.c_req | ~last_grant);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == S_DONE) begin
      last_grant <= grant_q;
    end
  end
`else
  assign pick_d = bus.d_req & ~bus.c_req;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      grant_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.c_req | bus.d_req) begin
            grant_q <= pick_d;
            we_q    <= pick_d ? bus.d_we    : bus.c_we;
            addr_q  <= pick_d ? bus.d_addr  : bus.c_addr;
            wdata_q <= pick_d ? bus.d_wdata : bus.c_wdata;
            cnt     <= CNT_LOAD;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            // Memory data is only valid on the last enabled cycle.
            if (!we_q) begin
              if (grant_q) begin
                d_rdata_q <= bus.m_rdata;
              end else begin
                c_rdata_q <= bus.m_rdata;
              end
            end
            state <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_en    = (state == S_ACCESS);
  assign bus.m_we    = (state == S_ACCESS) & we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.busy    = (state != S_IDLE);
  assign bus.grant   = grant_q;
  assign bus.c_ack   = (state == S_DONE) & ~grant_q;
  assign bus.d_ack   = (state == S_DONE) & grant_q;
  assign bus.c_rdata = c_rdata_q;
  assign bus.d_rdata = d_rdata_q;

endmodule
